// File: rtl/dcache_ctrl_fsm_pkg.sv
// Shared definitions for the data-cache controller: state encoding, address
// field positions, SRAM tag layout and line/word geometry.
package dcache_ctrl_fsm_pkg;

    localparam int WORD_W   = 32;
    localparam int LINE_W   = 256;
    localparam int IDX_W    = 4;
    localparam int TAG_W    = 25;
    localparam int ADDR_W   = 32;
    localparam int WORDS    = LINE_W / WORD_W;
    localparam int OFF_W    = 3;
    localparam int ATAG_W   = 23;

    // CPU byte address fields
    localparam int ATAG_LSB = 9;
    localparam int ATAG_MSB = 31;
    localparam int IDX_LSB  = 5;
    localparam int IDX_MSB  = 8;
    localparam int WORD_LSB = 2;
    localparam int WORD_MSB = 4;

    // SRAM tag word layout
    localparam int VALID_BIT = 24;
    localparam int DIRTY_BIT = 23;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MISS,
        ST_WRITEBACK,
        ST_READMISS,
        ST_READMISSOK
    } state_t;

    function automatic logic [ADDR_W-1:0] line_addr(input logic [ATAG_W-1:0] tag,
                                                     input logic [IDX_W-1:0]  idx);
        return {tag, idx, 5'b0};
    endfunction

endpackage

// File: rtl/dcache_ctrl_fsm_if.sv
// Bundle of the CPU, memory and SRAM ports seen by the cache controller.
interface dcache_ctrl_fsm_if;
    import dcache_ctrl_fsm_pkg::*;

    logic [ADDR_W-1:0] cpu_addr_i;
    logic [WORD_W-1:0] cpu_data_i;
    logic              cpu_MemRead_i;
    logic              cpu_MemWrite_i;
    logic [WORD_W-1:0] cpu_data_o;
    logic              cpu_stall_o;

    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [LINE_W-1:0] mem_data_i;
    logic              mem_ack_i;

    logic [IDX_W-1:0]  sram_addr_o;
    logic [TAG_W-1:0]  sram_tag_o;
    logic [LINE_W-1:0] sram_data_o;
    logic              sram_enable_o;
    logic              sram_write_o;
    logic [TAG_W-1:0]  sram_tag_i;
    logic [LINE_W-1:0] sram_data_i;
    logic              sram_hit_i;

    // master = controller, slave = CPU / memory / SRAM environment
    modport master (
        input  cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
        output cpu_data_o, cpu_stall_o,
        output mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
        input  mem_data_i, mem_ack_i,
        output sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
        input  sram_tag_i, sram_data_i, sram_hit_i
    );

    modport slave (
        output cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
        input  cpu_data_o, cpu_stall_o,
        input  mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
        output mem_data_i, mem_ack_i,
        input  sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
        output sram_tag_i, sram_data_i, sram_hit_i
    );

endinterface

// File: rtl/dcache_word_mux.sv
// Word select for loads and word merge for stores within one cache line.
module dcache_word_mux
    import dcache_ctrl_fsm_pkg::*;
(
    input  logic [LINE_W-1:0] line_i,
    input  logic [OFF_W-1:0]  sel_i,
    input  logic [WORD_W-1:0] wr_word_i,
    output logic [WORD_W-1:0] rd_word_o,
    output logic [LINE_W-1:0] merged_o
);

    logic [WORD_W-1:0] words [WORDS];

    // word 0 sits in the least significant bits of the line
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            assign words[gi] = line_i[gi*WORD_W +: WORD_W];
            assign merged_o[gi*WORD_W +: WORD_W] =
                (sel_i == OFF_W'(gi)) ? wr_word_i : line_i[gi*WORD_W +: WORD_W];
        end
    endgenerate

    assign rd_word_o = words[sel_i];

endmodule

// File: rtl/dcache_ctrl_fsm.sv
// Data-cache controller: serves hits from the 2-way SRAM in the same cycle and
// runs write-back / line-fetch sequences against memory on a miss.
module dcache_ctrl_fsm
    import dcache_ctrl_fsm_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    dcache_ctrl_fsm_if.master bus
);

    state_t            state_reg, state_next;
    logic [LINE_W-1:0] line_reg, line_next;
    logic [LINE_W-1:0] store_line;
    logic              req;
    logic [ATAG_W-1:0] addr_tag;
    logic [IDX_W-1:0]  addr_idx;
    logic              unused_addr_bits;

    assign req      = bus.cpu_MemRead_i | bus.cpu_MemWrite_i;
    assign addr_tag = bus.cpu_addr_i[ATAG_MSB:ATAG_LSB];
    assign addr_idx = bus.cpu_addr_i[IDX_MSB:IDX_LSB];
    assign unused_addr_bits = ^bus.cpu_addr_i[WORD_LSB-1:0];

    // Index and enable kept out of the FSM block so they never wait on the hit path
    assign bus.sram_addr_o   = addr_idx;
    assign bus.sram_enable_o = (state_reg == ST_IDLE) ? req : 1'b1;

    dcache_word_mux u_word_mux (
        .line_i    (bus.sram_data_i),
        .sel_i     (bus.cpu_addr_i[WORD_MSB:WORD_LSB]),
        .wr_word_i (bus.cpu_data_i),
        .rd_word_o (bus.cpu_data_o),
        .merged_o  (store_line)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
            line_reg  <= '0;
        end else begin
            state_reg <= state_next;
            line_reg  <= line_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        line_next        = line_reg;
        bus.cpu_stall_o  = 1'b1;
        bus.mem_enable_o = 1'b0;
        bus.mem_write_o  = 1'b0;
        bus.mem_addr_o   = line_addr(addr_tag, addr_idx);
        bus.mem_data_o   = bus.sram_data_i;
        bus.sram_write_o = 1'b0;
        bus.sram_tag_o   = {1'b1, 1'b0, addr_tag};
        bus.sram_data_o  = bus.sram_data_i;

        case (state_reg)
            ST_IDLE: begin
                bus.cpu_stall_o = 1'b0;
                if (req && !bus.sram_hit_i) begin
                    bus.cpu_stall_o = 1'b1;
                    state_next      = ST_MISS;
                end else if (req && bus.cpu_MemWrite_i) begin
                    bus.sram_write_o = 1'b1;
                    bus.sram_tag_o   = {1'b1, 1'b1, addr_tag};
                    bus.sram_data_o  = store_line;
                end
            end
            ST_MISS: begin
                if (bus.sram_tag_i[VALID_BIT] && bus.sram_tag_i[DIRTY_BIT])
                    state_next = ST_WRITEBACK;
                else
                    state_next = ST_READMISS;
            end
            ST_WRITEBACK: begin
                // SRAM is not written here, so victim tag/data stay stable until ack
                bus.mem_enable_o = 1'b1;
                bus.mem_write_o  = 1'b1;
                bus.mem_addr_o   = line_addr(bus.sram_tag_i[ATAG_W-1:0], addr_idx);
                if (bus.mem_ack_i)
                    state_next = ST_READMISS;
            end
            ST_READMISS: begin
                bus.mem_enable_o = 1'b1;
                if (bus.mem_ack_i) begin
                    line_next  = bus.mem_data_i;
                    state_next = ST_READMISSOK;
                end
            end
            ST_READMISSOK: begin
                // A miss-write makes the SRAM fill its LRU way with the fetched line
                bus.sram_write_o = 1'b1;
                bus.sram_data_o  = line_reg;
                state_next       = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: doc/dcache_ctrl_fsm.md
Name: dcache_ctrl_fsm

Overview:
Cache controller that sits between the CPU MEM stage, the 2-way data-cache SRAM and the off-chip data memory. It decodes CPU load/store requests and drives the SRAM's index/tag/data/enable/write port. It runs the write-back and allocate sequences against memory on a miss, and stalls the pipeline until the access hits. It is the initiator for the SRAM port and the requester for the memory port.

Parameters:
WORD_W, 32, CPU data word width
LINE_W, 256, cache line width (8 words, 32 bytes)
IDX_W, 4, set index width (16 sets)
TAG_W, 25, SRAM tag field: bit24 valid, bit23 dirty, bits22:0 address tag

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
cpu_addr_i  in  32  byte address; [31:9] tag, [8:5] index, [4:2] word offset
cpu_data_i  in  32  store data
cpu_MemRead_i  in  1  load request
cpu_MemWrite_i  in  1  store request
cpu_data_o  out  32  load data
cpu_stall_o  out  1  pipeline stall
mem_addr_o  out  32  line address, [4:0]=0
mem_data_o  out  256  write-back line
mem_enable_o  out  1  memory request valid
mem_write_o  out  1  1=write-back, 0=line fetch
mem_data_i  in  256  fetched line
mem_ack_i  in  1  one-cycle completion pulse
sram_addr_o  out  4  set index
sram_tag_o  out  25  tag to compare/write
sram_data_o  out  256  line to write
sram_enable_o  out  1  SRAM access enable
sram_write_o  out  1  SRAM write strobe
sram_tag_i  in  25  hit tag, else LRU victim tag (0 if victim invalid)
sram_data_i  in  256  hit line, else victim line
sram_hit_i  in  1  tag hit

Behaviour:
- req = cpu_MemRead_i | cpu_MemWrite_i. If both are high, the request is treated as a store.
- sram_addr_o = cpu_addr_i[8:5] in all states. sram_enable_o = req in IDLE, 1 in all other states.
- States: IDLE, MISS, WRITEBACK, READMISS, READMISSOK. Reset -> IDLE.
- Reset values: mem_enable_o=0, mem_write_o=0, sram_write_o=0, cpu_stall_o=0, refill line register=0.
- IDLE, load hit: cpu_data_o = sram_data_i word selected by [4:2] (word 0 = bits 31:0), combinational, same cycle. cpu_stall_o=0.
- IDLE, store hit: same cycle, sram_write_o=1. sram_data_o = sram_data_i with the selected word replaced by cpu_data_i. sram_tag_o={1,1,addr[31:9]}. cpu_stall_o=0.
- IDLE, req & ~sram_hit_i: cpu_stall_o=1 combinationally; next state MISS.
- MISS (1 cycle):
  - If sram_tag_i[24] & sram_tag_i[23] (victim valid and dirty) -> WRITEBACK.
  - Otherwise -> READMISS.
- WRITEBACK:
  - mem_enable_o=1, mem_write_o=1.
  - mem_addr_o={sram_tag_i[22:0], index, 5'b0}; mem_data_o=sram_data_i. Both are held stable until ack.
  - On mem_ack_i -> READMISS.
- READMISS:
  - mem_enable_o=1, mem_write_o=0, mem_addr_o={addr[31:9], index, 5'b0}.
  - On mem_ack_i: register mem_data_i, then -> READMISSOK.
- READMISSOK (1 cycle):
  - sram_write_o=1, sram_data_o=registered line, sram_tag_o={1,0,addr[31:9]}.
  - The SRAM treats this as a write miss: it fills the LRU way and flips LRU.
  - Next state IDLE. The retried access then hits, and a store marks the line dirty via the store-hit path.
- cpu_stall_o=1 in every state except IDLE. Minimum miss penalty is 3 cycles plus memory latency (clean victim), plus one more memory latency when the victim is dirty.
- mem_enable_o is level and deasserts in the cycle after ack is sampled. There is no new request on the ack cycle.
- mem_ack_i is ignored in IDLE, MISS and READMISSOK.
- If the CPU request drops mid-miss, the sequence still completes to IDLE. There is no abort.
- If rst_i is asserted mid-operation, the next edge returns to IDLE and mem_enable_o=0. The outstanding memory transaction is abandoned, and memory must tolerate this.
- The CPU address and data must be held stable while cpu_stall_o=1.

Decomposition:
- Shared package holds:
  - state encoding;
  - address field positions (tag [31:9], index [8:5], word [4:2]);
  - SRAM tag bit positions (VALID=24, DIRTY=23);
  - LINE_W/WORD_W constants.
- One natural sub-module: dcache_word_mux, the 8:1 word select for loads and the word-merge for stores.

Test Plan:
- Cold load: load addr 0x0000_0424, memory line at 0x420 has word1=0xDEADBEEF, ack after 5 cycles -> stall through READMISSOK, single memory read to 0x0000_0420, then cpu_data_o=0xDEADBEEF with stall=0.
- Store hit: after the cold load, store 0x12345678 to 0x0000_0428 -> no stall, sram_write_o pulse, sram_tag_o={1,1,0x000002}, word2 merged.
- Dirty eviction:
  - Sequence: fill both ways of set 1 (0x0420, 0x0820), dirty the LRU way, then load 0x0C20.
  - Required: memory write to the LRU way's address with the dirty line, then a read of 0x0000_0C20; two mem_enable_o bursts.
- Clean eviction: same set sequence with no store -> no mem_write_o, a single read only.
- Reset mid-WRITEBACK: assert rst_i for 1 cycle while mem_enable_o=1 -> mem_enable_o=0 and stall=0 next cycle; state IDLE.
- Spurious mem_ack_i in IDLE with load hit -> no state change, correct data returned.
